uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised, runtime-configurable UART transmitter. Successor to the fixed 8-bit single-mode transmitter.
- Frame format: one start bit, DATA_BITS data bits sent LSB first, optional even or odd parity, then 1 or 2 stop bits.
- Bit timing comes from the shared baud-rate tick generator, which runs at OVERSAMPLE ticks per bit.
- Has a ready/start handshake and a done pulse so a FIFO or CPU-side controller can stream bytes back-to-back.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, s_tick pulses per bit period; must be at least 2.
- TICK_W, $clog2(OVERSAMPLE), width of the tick counter.
- BIT_W, 4, width of the bit counter; must hold DATA_BITS+3.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- s_tick  in  1  one-cycle oversample tick from the baud generator.
- tx_start  in  1  frame request; accepted only while tx_ready=1.
- tx_data  in  DATA_BITS  frame payload; latched on acceptance.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; latched on acceptance.
- stop2  in  1  0 means one stop bit, 1 means two; latched on acceptance.
- tx_out  out  1  serial line, idles high.
- tx_ready  out  1  high when a new frame can be accepted.
- tx_busy  out  1  high while a frame is in progress (equals ~tx_ready when the break feature is absent).
- tx_done  out  1  one-cycle pulse at frame end.
- break_req  in  1  present only when UART_TX_BREAK_EN is defined.

Behaviour:
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, all counters 0, shift register 0.
- Reset mid-frame: the frame is abandoned and the reset values apply on the next cycle. No done pulse is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When tx_start=1, latch tx_data, parity_mode and stop2, then go to START.
  - Compute the parity bit at latch time: even mode gives XOR of the data; odd mode gives its inverse.
- Latency: tx_out goes low on the cycle after the acceptance edge.
- Registered outputs: tx_out is registered; there is no combinational path from inputs to tx_out.
- Tick counting: each bit lasts exactly OVERSAMPLE s_tick pulses. The tick counter advances only on s_tick and is cleared in IDLE.
- Bit advance happens on the s_tick where tick_cnt==OVERSAMPLE-1. At that point tick_cnt wraps to 0 and the bit counter increments.
- Transitions:
  - START to DATA after 1 bit period.
  - DATA to PARITY after DATA_BITS bit periods when parity is enabled; otherwise DATA to STOP.
  - PARITY to STOP after 1 bit period.
  - STOP to IDLE after 1 bit period when stop2=0, or after 2 bit periods when stop2=1.
- tx_out by state:
  - START: 0.
  - DATA: shift_reg[0]; the register shifts right at each bit advance.
  - PARITY: the latched parity bit.
  - STOP and IDLE: 1.
- Frame end: on the edge that leaves STOP, tx_done=1 for exactly one cycle and tx_ready=1 in that same cycle.
- Back-to-back: a tx_start present in the tx_done cycle is accepted, so consecutive frames have no idle gap beyond the stop bits.
- tx_start while busy: ignored. tx_data and the mode inputs may change freely mid-frame without effect.
- s_tick and tx_start in the same IDLE cycle: the request is accepted. That tick is not counted toward the start bit.
- s_tick held high continuously is legal; each cycle then counts as one tick.
- Illegal state encoding: recovers to IDLE with tx_out=1.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined:
  - The break_req port exists.
  - In IDLE with break_req=1 (it takes priority over tx_start), enter BREAK: tx_out=0, tx_ready=0, tx_busy=1 for as long as break_req stays high.
  - On release, go to BREAK_MARK: drive tx_out=1 for exactly one bit period (OVERSAMPLE ticks), then return to IDLE and pulse tx_done.
  - break_req asserted mid-frame is ignored until the block is back in IDLE.
- When not defined: there is no port and no BREAK states, and behaviour is exactly as above.

Test Plan:
- OVERSAMPLE=16, s_tick every cycle, tx_data=0xA5, parity 00, stop2=0 -> tx_out reads 0,1,0,1,0,0,1,0,1,1, each held 16 cycles. tx_done pulses exactly 160 cycles after the acceptance edge.
- tx_data=0x07 with even parity -> parity bit 1. tx_data=0x00 with odd parity -> parity bit 1. Frame length is 11 bit periods in both cases.
- stop2=1, parity 00 -> line high for 32 ticks after the last data bit. tx_ready stays 0 until that point.
- Pulse tx_start with new data during DATA -> ignored; the frame in progress and tx_ready are unaffected.
- Hold tx_start high with 0x55 then 0x33 -> second start bit begins 1 cycle after tx_done, with no extra idle bits.
- Assert reset at the midpoint of bit 4 -> next cycle tx_out=1, tx_ready=1, no tx_done pulse. A following tx_start sends a clean frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK / BREAK_MARK line-break states.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_W     = $clog2(OVERSAMPLE),
    parameter int BIT_W      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 tx_out,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK      = 3'd5,
        S_BREAK_MARK = 3'd6
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_en_q, parity_en_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_done_q, tx_done_d;
    logic                 bit_adv;

    // Last oversample tick of the current bit period.
    assign bit_adv = s_tick && (tick_cnt_q == TICK_LAST);

    // State register and datapath flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            parity_en_q  <= 1'b0;
            stop2_q      <= 1'b0;
            tx_out_q     <= 1'b1;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            parity_en_q  <= parity_en_d;
            stop2_q      <= stop2_d;
            tx_out_q     <= tx_out_d;
            tx_done_q    <= tx_done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        parity_en_d  = parity_en_q;
        stop2_d      = stop2_q;

        if (s_tick) begin
            tick_cnt_d = bit_adv ? '0 : tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                // A tick arriving with the request is deliberately not counted.
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = S_BREAK;
                end else
`endif
                if (tx_start) begin
                    state_d      = S_START;
                    shift_d      = tx_data;
                    parity_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    parity_bit_d = (parity_mode == 2'b10) ^ (^tx_data);
                    stop2_d      = stop2;
                end
            end
            S_START: begin
                if (bit_adv) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_adv) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = parity_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_adv) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (bit_adv) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                tick_cnt_d = '0;
                if (!break_req) begin
                    state_d = S_BREAK_MARK;
                end
            end
            S_BREAK_MARK: begin
                if (bit_adv) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx_out stays a pure flop output.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
            S_PARITY: tx_out_d = parity_bit_d;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_out_d = 1'b0;
`endif
            default:  tx_out_d = 1'b1;
        endcase

`ifdef UART_TX_BREAK_EN
        tx_done_d = ((state_q == S_STOP) || (state_q == S_BREAK_MARK)) && (state_d == S_IDLE);
`else
        tx_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
`endif
    end

    assign tx_out   = tx_out_q;
    assign tx_done  = tx_done_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (default build): frame shapes, parity, stop bits, handshake and reset abort.
module tb_uart_tx_cfg;

    logic       clock;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       tx_out;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
`ifdef UART_TX_BREAK_EN
    logic       break_req;
`endif

    logic [3:0] obs_vec;
    int         errors;
    int         checks;

    uart_tx_cfg #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s_tick      (s_tick),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .parity_mode (parity_mode),
        .stop2       (stop2),
`ifdef UART_TX_BREAK_EN
        .break_req   (break_req),
`endif
        .tx_out      (tx_out),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed as {tx_out, tx_ready, tx_busy, tx_done}.
    assign obs_vec = {tx_out, tx_ready, tx_busy, tx_done};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the first negedge after acceptance.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2);
        tx_data     = d;
        parity_mode = pm;
        stop2       = s2;
        tx_start    = 1'b1;
        @(negedge clock);
        tx_start    = 1'b0;
    endtask

    // bits[i] is the i-th line level of the frame; cpb=32 means s_tick every other cycle.
    task automatic expect_frame(input logic [15:0] bits, input int nbits, input int cpb,
                                input string tag, input int inject_at);
        for (int k = 1; k <= nbits * cpb; k++) begin
            check($sformatf("%s_k%0d", tag, k), obs_vec, {bits[(k-1)/cpb], 3'b010});
            if (cpb != 16) s_tick = ((k % 2) == 0);
            if (k == inject_at) begin
                tx_start    = 1'b1;
                tx_data     = 8'hFF;
                parity_mode = 2'b01;
                stop2       = 1'b1;
            end else if (k == inject_at + 1) begin
                tx_start = 1'b0;
            end
            @(negedge clock);
        end
        s_tick = 1'b1;
        check($sformatf("%s_done", tag), obs_vec, 4'b1101);
        $display("frame %s: %0d bits, %0d cycles per bit", tag, nbits, cpb);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clock);
        check(tag, obs_vec, 4'b1100);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        s_tick      = 1'b1;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        parity_mode = 2'b00;
        stop2       = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req   = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("reset_state", obs_vec, 4'b1100);
        reset = 1'b0;
        idle_check("idle_after_reset");

        // 0xA5, no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1
        start_frame(8'hA5, 2'b00, 1'b0);
        expect_frame(16'h034A, 10, 16, "a5", -1);
        idle_check("idle_a5");

        // 0x07 even parity -> parity 1
        start_frame(8'h07, 2'b01, 1'b0);
        expect_frame(16'h060E, 11, 16, "07even", -1);
        idle_check("idle_07");

        // 0x00 odd parity -> parity 1
        start_frame(8'h00, 2'b10, 1'b0);
        expect_frame(16'h0600, 11, 16, "00odd", -1);
        idle_check("idle_00");

        // 0x3C two stop bits
        start_frame(8'h3C, 2'b00, 1'b1);
        expect_frame(16'h0678, 11, 16, "3cstop2", -1);
        idle_check("idle_3c");

        // 0x5A with a new request and changed inputs mid-DATA
        start_frame(8'h5A, 2'b00, 1'b0);
        expect_frame(16'h02B4, 10, 16, "5aignore", 70);
        idle_check("idle_5a");

        // Back-to-back: tx_start held through 0x55 then 0x33
        tx_data     = 8'h55;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        tx_start    = 1'b1;
        @(negedge clock);
        expect_frame(16'h02AA, 10, 16, "b2b55", -1);
        tx_data = 8'h33;
        @(negedge clock);
        tx_start = 1'b0;
        expect_frame(16'h0266, 10, 16, "b2b33", -1);
        idle_check("idle_b2b");

        // 0x0F with s_tick every other cycle
        start_frame(8'h0F, 2'b00, 1'b0);
        expect_frame(16'h021E, 10, 32, "0fslow", -1);
        idle_check("idle_0f");

        // Reset at the midpoint of data bit 4 of a 0x00 frame
        start_frame(8'h00, 2'b00, 1'b0);
        for (int k = 1; k < 89; k++) @(negedge clock);
        check("mid_bit4", obs_vec, 4'b0010);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_frame", obs_vec, 4'b1100);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) idle_check($sformatf("post_rst_%0d", k));
        $display("reset abort at data bit 4 applied");

        start_frame(8'hA5, 2'b00, 1'b0);
        expect_frame(16'h034A, 10, 16, "a5clean", -1);
        idle_check("idle_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
